// File: rtl/pie_tx_pkg.sv
// Shared types, reset defaults and config validation for the PIE transmit encoder.
// Optional CW hold after the last symbol is enabled by defining PIE_TX_CW_HOLD_EN.
package pie_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_DATA0,
    ST_RTCAL,
    ST_TRCAL,
    ST_DATA,
    ST_CWHOLD
  } pie_state_t;

  localparam int PIE_DEF_PW    = 2;
  localparam int PIE_DEF_TARI  = 6;
  localparam int PIE_DEF_ONE   = 10;
  localparam int PIE_DEF_DELIM = 3;
  localparam int PIE_DEF_TRCAL = 32;
  localparam int PIE_DEF_CW    = 8;

  // A frame is only legal if every symbol still has a high phase and data-1 is longer than data-0.
  function automatic logic cfg_valid(input logic [31:0] pw,
                                     input logic [31:0] tari,
                                     input logic [31:0] one,
                                     input logic [31:0] delim);
    return (pw != 32'd0) && (pw < tari) && (tari < one) && (delim != 32'd0);
  endfunction

endpackage

// File: rtl/pie_tx_encoder_symbol_timer.sv
// Single reusable symbol timer: loaded with a period and low-pulse width, it produces
// registered level, end-of-symbol and handshake-request flags for the current cycle.
module pie_symbol_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W:0]   period,
  input  logic [CNT_W-1:0] pw,
  input  logic             hs,
  output logic             level,
  output logic             sym_end,
  output logic             hs_end
);

  localparam logic [CNT_W:0] ONE_P = (CNT_W+1)'(1);

  logic [CNT_W:0]   cnt_reg;
  logic [CNT_W:0]   period_reg;
  logic [CNT_W-1:0] pw_reg;
  logic             hs_reg;
  logic             run_reg;
  logic             level_reg;
  logic             end_reg;
  logic             rdy_reg;
  logic [CNT_W:0]   cnt_next;

  assign cnt_next = cnt_reg + ONE_P;

  // High while c < P-pw, written as c+pw < P so a short period never wraps.
  function automatic logic lvl_at(input logic [CNT_W:0] c,
                                  input logic [CNT_W:0] p,
                                  input logic [CNT_W-1:0] w);
    return ({1'b0, c} + {2'b00, w}) < {1'b0, p};
  endfunction

  // A zero period is treated as a single-cycle symbol so the FSM can never stall.
  function automatic logic end_at(input logic [CNT_W:0] c,
                                  input logic [CNT_W:0] p);
    return (p == '0) ? 1'b1 : (c == (p - ONE_P));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      pw_reg     <= '0;
      hs_reg     <= 1'b0;
      run_reg    <= 1'b0;
      level_reg  <= 1'b1;
      end_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else if (load) begin
      cnt_reg    <= '0;
      period_reg <= period;
      pw_reg     <= pw;
      hs_reg     <= hs;
      run_reg    <= 1'b1;
      level_reg  <= lvl_at('0, period, pw);
      end_reg    <= end_at('0, period);
      rdy_reg    <= hs & end_at('0, period);
    end else if (clear) begin
      cnt_reg    <= '0;
      hs_reg     <= 1'b0;
      run_reg    <= 1'b0;
      level_reg  <= 1'b1;
      end_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else if (run_reg) begin
      cnt_reg    <= cnt_next;
      level_reg  <= lvl_at(cnt_next, period_reg, pw_reg);
      end_reg    <= end_at(cnt_next, period_reg);
      rdy_reg    <= hs_reg & end_at(cnt_next, period_reg);
    end
  end

  assign level   = level_reg;
  assign sym_end = end_reg;
  assign hs_end  = rdy_reg;

endmodule

// File: rtl/pie_tx_encoder.sv
// PIE reader-to-tag transmit encoder: delimiter, data-0, RTCAL, optional TRCAL, data bits.
// Define PIE_TX_CW_HOLD_EN to add a carrier hold of cfg_cw cycles after the last symbol.
module pie_tx_encoder
  import pie_tx_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEF_PW    = PIE_DEF_PW,
  parameter int DEF_TARI  = PIE_DEF_TARI,
  parameter int DEF_ONE   = PIE_DEF_ONE,
  parameter int DEF_DELIM = PIE_DEF_DELIM,
  parameter int DEF_TRCAL = PIE_DEF_TRCAL,
  parameter int DEF_CW    = PIE_DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frm_start,
  input  logic             frm_preamble,
  input  logic [CNT_W-1:0] cfg_pw,
  input  logic [CNT_W-1:0] cfg_tari,
  input  logic [CNT_W-1:0] cfg_one,
  input  logic [CNT_W-1:0] cfg_delim,
  input  logic [CNT_W-1:0] cfg_trcal,
  input  logic [CNT_W-1:0] cfg_cw,
  input  logic             in_dat,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             out_pie,
  output logic             busy,
  output logic             done,
  output logic             err
);

  pie_state_t       state_reg, state_next;
  logic [CNT_W-1:0] pw_reg, tari_reg, one_reg, delim_reg, trcal_reg, cw_reg;
  logic             pre_reg;
  logic             last_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             load, clear, latch_cfg, take_bit;
  logic             handshake, finish, go_idle;
  logic [CNT_W:0]   ld_period;
  logic [CNT_W-1:0] ld_pw;
  logic             ld_hs;
  logic [CNT_W:0]   rtcal_period;
  logic             sym_level, sym_end, sym_hs_end;
  logic             unused_bits;

  assign rtcal_period = {1'b0, tari_reg} + {1'b0, one_reg};
  assign unused_bits  = ^{delim_reg, cw_reg};

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;
    latch_cfg  = 1'b0;
    take_bit   = 1'b0;
    handshake  = 1'b0;
    finish     = 1'b0;
    go_idle    = 1'b0;
    ld_period  = {1'b0, tari_reg};
    ld_pw      = pw_reg;
    ld_hs      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (frm_start) begin
          if (!cfg_valid(32'(cfg_pw), 32'(cfg_tari), 32'(cfg_one), 32'(cfg_delim))) begin
            err_next = 1'b1;
          end else begin
            // Delimiter is a symbol whose low phase spans the whole period.
            latch_cfg  = 1'b1;
            load       = 1'b1;
            ld_period  = {1'b0, cfg_delim};
            ld_pw      = cfg_delim;
            state_next = ST_DELIM;
            busy_next  = 1'b1;
          end
        end
      end
      ST_DELIM: begin
        if (sym_end) begin
          load       = 1'b1;
          ld_period  = {1'b0, tari_reg};
          state_next = ST_DATA0;
        end
      end
      ST_DATA0: begin
        if (sym_end) begin
          load       = 1'b1;
          ld_period  = rtcal_period;
          ld_hs      = ~pre_reg;
          state_next = ST_RTCAL;
        end
      end
      ST_RTCAL: begin
        if (sym_end) begin
          if (pre_reg) begin
            load       = 1'b1;
            ld_period  = {1'b0, trcal_reg};
            ld_hs      = 1'b1;
            state_next = ST_TRCAL;
          end else begin
            handshake = 1'b1;
          end
        end
      end
      ST_TRCAL: begin
        if (sym_end) handshake = 1'b1;
      end
      ST_DATA: begin
        if (sym_end) begin
          if (last_reg) finish = 1'b1;
          else          handshake = 1'b1;
        end
      end
      ST_CWHOLD: begin
        if (sym_end) go_idle = 1'b1;
      end
      default: begin
        clear      = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    if (handshake) begin
      if (in_vld) begin
        load       = 1'b1;
        take_bit   = 1'b1;
        ld_period  = in_dat ? {1'b0, one_reg} : {1'b0, tari_reg};
        ld_hs      = ~in_last;
        state_next = ST_DATA;
      end else begin
        // Underrun: abandon the frame with the carrier on.
        clear      = 1'b1;
        err_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    end

    if (finish) begin
`ifdef PIE_TX_CW_HOLD_EN
      if (cw_reg != '0) begin
        load       = 1'b1;
        ld_period  = {1'b0, cw_reg};
        ld_pw      = '0;
        state_next = ST_CWHOLD;
      end else begin
        go_idle = 1'b1;
      end
`else
      go_idle = 1'b1;
`endif
    end

    if (go_idle) begin
      clear      = 1'b1;
      done_next  = 1'b1;
      busy_next  = 1'b0;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      pw_reg    <= CNT_W'(DEF_PW);
      tari_reg  <= CNT_W'(DEF_TARI);
      one_reg   <= CNT_W'(DEF_ONE);
      delim_reg <= CNT_W'(DEF_DELIM);
      trcal_reg <= CNT_W'(DEF_TRCAL);
      cw_reg    <= CNT_W'(DEF_CW);
      pre_reg   <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (latch_cfg) begin
        pw_reg    <= cfg_pw;
        tari_reg  <= cfg_tari;
        one_reg   <= cfg_one;
        delim_reg <= cfg_delim;
        trcal_reg <= cfg_trcal;
        cw_reg    <= cfg_cw;
        pre_reg   <= frm_preamble;
      end
      if (take_bit) last_reg <= in_last;
    end
  end

  pie_symbol_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .period  (ld_period),
    .pw      (ld_pw),
    .hs      (ld_hs),
    .level   (sym_level),
    .sym_end (sym_end),
    .hs_end  (sym_hs_end)
  );

  assign out_pie = sym_level;
  assign in_rdy  = sym_hs_end;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_pie_tx_encoder.sv
// Randomized self-checking bench for pie_tx_encoder against a per-cycle waveform list model.
// Build with +define+PIE_TX_CW_HOLD_EN to cover the CW hold variant.
module tb_pie_tx_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frm_start = 1'b0;
  logic       frm_preamble = 1'b0;
  logic [7:0] cfg_pw = 8'd2, cfg_tari = 8'd6, cfg_one = 8'd10;
  logic [7:0] cfg_delim = 8'd3, cfg_trcal = 8'd32, cfg_cw = 8'd0;
  logic       in_dat = 1'b0, in_last = 1'b0, in_vld = 1'b0;
  logic       in_rdy, out_pie, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  int c_pw, c_tari, c_one, c_delim, c_trcal, c_cw;
  int bits_a[16];
  bit exp_lvl[$];
  bit exp_rdy[$];

`ifdef PIE_TX_CW_HOLD_EN
  localparam bit CW_ON = 1'b1;
`else
  localparam bit CW_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pie_tx_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .frm_start    (frm_start),
    .frm_preamble (frm_preamble),
    .cfg_pw       (cfg_pw),
    .cfg_tari     (cfg_tari),
    .cfg_one      (cfg_one),
    .cfg_delim    (cfg_delim),
    .cfg_trcal    (cfg_trcal),
    .cfg_cw       (cfg_cw),
    .in_dat       (in_dat),
    .in_last      (in_last),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .out_pie      (out_pie),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic drive_cfg();
    cfg_pw    = 8'(c_pw);
    cfg_tari  = 8'(c_tari);
    cfg_one   = 8'(c_one);
    cfg_delim = 8'(c_delim);
    cfg_trcal = 8'(c_trcal);
    cfg_cw    = 8'(c_cw);
  endtask

  // Append one symbol of period p: high for the first p-w cycles, low for the last w.
  task automatic add_sym(input int p, input int w, input bit hs);
    for (int c = 0; c < p; c++) begin
      exp_lvl.push_back(c < p - w);
      exp_rdy.push_back(hs && (c == p - 1));
    end
  endtask

  task automatic build_model(input bit pre, input int n, input int under_h);
    int h;
    exp_lvl.delete();
    exp_rdy.delete();
    for (int i = 0; i < c_delim; i++) begin
      exp_lvl.push_back(1'b0);
      exp_rdy.push_back(1'b0);
    end
    add_sym(c_tari, c_pw, 1'b0);
    add_sym(c_tari + c_one, c_pw, !pre);
    if (pre) add_sym(c_trcal, c_pw, 1'b1);
    for (int i = 0; i < n; i++)
      add_sym(bits_a[i] != 0 ? c_one : c_tari, c_pw, i != n - 1);
    if (CW_ON) add_sym(c_cw, 0, 1'b0);
    if (under_h >= 0) begin
      h = 0;
      for (int i = 0; i < exp_rdy.size(); i++) begin
        if (exp_rdy[i]) begin
          if (h == under_h) begin
            while (exp_lvl.size() > i + 1) begin
              void'(exp_lvl.pop_back());
              void'(exp_rdy.pop_back());
            end
            break;
          end
          h++;
        end
      end
    end
  endtask

  task automatic run_frame(input string name, input bit pre, input int n, input int under_h,
                           input bit chaos, output int busy_seen);
    int len;
    int h;
    bit exp_err;
    build_model(pre, n, under_h);
    len = exp_lvl.size();
    exp_err = (under_h >= 0);
    busy_seen = 0;
    h = 0;
    @(posedge clk); #1;
    drive_cfg();
    frm_start = 1'b1;
    frm_preamble = pre;
    in_vld = 1'b0;
    for (int cyc = 0; cyc < len; cyc++) begin
      @(posedge clk); #1;
      frm_start = chaos ? 1'($urandom_range(0, 1)) : 1'b0;
      if (chaos) begin
        cfg_pw = 8'($urandom_range(0, 255));
        cfg_tari = 8'($urandom_range(0, 255));
        cfg_one = 8'($urandom_range(0, 255));
        cfg_delim = 8'($urandom_range(0, 255));
        cfg_trcal = 8'($urandom_range(0, 255));
        cfg_cw = 8'($urandom_range(0, 255));
        frm_preamble = 1'($urandom_range(0, 1));
      end
      if (exp_rdy[cyc]) begin
        in_vld = (h != under_h);
        in_dat = (bits_a[h] != 0);
        in_last = (h == n - 1);
        h++;
      end else begin
        in_vld = 1'($urandom_range(0, 1));
        in_dat = 1'($urandom_range(0, 1));
        in_last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check_val("out_pie", int'(out_pie), int'(exp_lvl[cyc]));
      check_val("in_rdy", int'(in_rdy), int'(exp_rdy[cyc]));
      check_val("busy", int'(busy), 1);
      check_val("done_mid", int'(done), 0);
      check_val("err_mid", int'(err), 0);
      busy_seen += int'(busy);
    end
    @(posedge clk); #1;
    frm_start = 1'b0;
    in_vld = 1'b0;
    drive_cfg();
    @(negedge clk);
    check_val("done_end", int'(done), int'(!exp_err));
    check_val("err_end", int'(err), int'(exp_err));
    check_val("busy_end", int'(busy), 0);
    check_val("out_pie_end", int'(out_pie), 1);
    check_val("in_rdy_end", int'(in_rdy), 0);
    check_val("busy_len", busy_seen, len);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("done_pulse", int'(done), 0);
    check_val("err_pulse", int'(err), 0);
    $display("frame %s pre=%0d bits=%0d underrun=%0d chaos=%0d busy_cycles=%0d",
             name, pre, n, under_h, chaos, busy_seen);
  endtask

  task automatic bad_cfg(input int kind);
    c_pw = 2; c_tari = 6; c_one = 10; c_delim = 3;
    case (kind)
      0: c_pw = 0;
      1: c_pw = 6;
      2: c_one = 6;
      default: c_delim = 0;
    endcase
    @(posedge clk); #1;
    drive_cfg();
    frm_start = 1'b1;
    @(posedge clk); #1;
    frm_start = 1'b0;
    @(negedge clk);
    check_val("cfg_err", int'(err), 1);
    check_val("cfg_busy", int'(busy), 0);
    check_val("cfg_out", int'(out_pie), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("cfg_err_clr", int'(err), 0);
    check_val("cfg_busy2", int'(busy), 0);
    check_val("cfg_out2", int'(out_pie), 1);
    $display("bad config kind=%0d pw=%0d tari=%0d one=%0d delim=%0d", kind, c_pw, c_tari, c_one, c_delim);
  endtask

  task automatic reset_mid_trcal();
    int wait_cyc;
    c_pw = 2; c_tari = 6; c_one = 10; c_delim = 3; c_trcal = 32; c_cw = 0;
    wait_cyc = c_delim + c_tari + c_tari + c_one + 10;
    @(posedge clk); #1;
    drive_cfg();
    frm_start = 1'b1;
    frm_preamble = 1'b1;
    in_vld = 1'b1;
    for (int i = 0; i < wait_cyc; i++) begin
      @(posedge clk); #1;
      frm_start = 1'b0;
    end
    @(negedge clk);
    check_val("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check_val("rst_out", int'(out_pie), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_rdy", int'(in_rdy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    in_vld = 1'b0;
    $display("async reset mid-TRCAL after %0d cycles", wait_cyc);
  endtask

  initial begin
    int bs;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", int'(out_pie), 1);
    check_val("reset_rdy", int'(in_rdy), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;

    c_pw = 2; c_tari = 6; c_one = 10; c_delim = 3; c_trcal = 32; c_cw = 8;
    bits_a[0] = 1; bits_a[1] = 0;
    run_frame("plan_pre", 1'b1, 2, -1, 1'b0, bs);
    check_val("plan_pre_len", bs, 73 + (CW_ON ? 8 : 0));
    run_frame("plan_sync", 1'b0, 2, -1, 1'b0, bs);
    check_val("plan_sync_len", bs, 41 + (CW_ON ? 8 : 0));
    run_frame("plan_underrun", 1'b1, 2, 1, 1'b0, bs);
    run_frame("plan_chaos", 1'b1, 2, -1, 1'b1, bs);
    check_val("plan_chaos_len", bs, 73 + (CW_ON ? 8 : 0));
    for (int k = 0; k < 4; k++) bad_cfg(k);
    reset_mid_trcal();
    c_pw = 2; c_tari = 6; c_one = 10; c_delim = 3; c_trcal = 32; c_cw = 0;
    run_frame("after_reset", 1'b1, 2, -1, 1'b0, bs);

    for (int f = 0; f < 30; f++) begin
      c_pw = $urandom_range(1, 3);
      c_tari = c_pw + $urandom_range(1, 4);
      c_one = c_tari + $urandom_range(1, 6);
      c_delim = $urandom_range(1, 4);
      c_trcal = $urandom_range(c_pw + 1, 40);
      c_cw = $urandom_range(0, 5);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) bits_a[i] = $urandom_range(0, 1);
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), n,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                1'($urandom_range(0, 1)), bs);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
